// File: rtl/qpsk_symbol_packer.sv
// -----------------------------------------------------------------------------
// qpsk_symbol_packer
//
// Takes the phase-corrected I/Q sample streams from the Costas loop, runs an
// integrate-and-dump matched filter over SPS samples per symbol, hard-slices
// each symbol to a Gray-coded QPSK dibit, packs four dibits per byte (first
// symbol in bits [7:6]) and emits the bytes on one AXI-stream output through
// a 2-entry FIFO. Every BYTES_PER_PKT-th byte carries tlast.
//
// Ports
//   ce_clk, ce_rst          block clock, asynchronous active-high reset
//   s_axis_i_* / s_axis_q_* signed 16-bit I and Q sample streams; a pair is
//                           consumed only when both valids and tready are high
//   m_axis_*                packed symbol bytes with packet framing (tlast)
//   sym_lock_cnt            number of symbols decided since reset (wraps)
// -----------------------------------------------------------------------------
module qpsk_symbol_packer #(
    parameter int SPS           = 8,
    parameter int BYTES_PER_PKT = 64,
    parameter int ACC_W         = 16 + $clog2(SPS)
) (
    input  logic                ce_clk,
    input  logic                ce_rst,
    input  logic signed [15:0]  s_axis_i_tdata,
    input  logic                s_axis_i_tvalid,
    output logic                s_axis_i_tready,
    input  logic signed [15:0]  s_axis_q_tdata,
    input  logic                s_axis_q_tvalid,
    output logic                s_axis_q_tready,
    output logic [7:0]          m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic [15:0]         sym_lock_cnt
);

    localparam int CNT_W = $clog2(SPS);
    localparam int BC_W  = (BYTES_PER_PKT > 1) ? $clog2(BYTES_PER_PKT) : 1;

    localparam logic [CNT_W-1:0] LAST_SMP  = CNT_W'(SPS - 1);
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(BYTES_PER_PKT - 1);

    // Sign-extend a 16-bit sample to the accumulator width.
    function automatic logic signed [ACC_W-1:0] sext(input logic signed [15:0] x);
        return {{(ACC_W - 16){x[15]}}, x};
    endfunction

    // Hard decision: negative sums map to 1, zero counts as positive.
    function automatic logic slice_neg(input logic signed [ACC_W-1:0] s);
        return (s < 0);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                    run_q;
    logic [CNT_W-1:0]        smp_cnt_q, smp_cnt_d;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
    logic [1:0]              dib_cnt_q, dib_cnt_d;
    logic [5:0]              shreg_q, shreg_d;
    logic [BC_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [15:0]             sym_cnt_q, sym_cnt_d;
    logic [8:0]              mem_q [2];
    logic [8:0]              mem_d [2];
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              fill_q, fill_d;

    // ------------------------------------------------------------------
    // Handshakes and datapath
    // ------------------------------------------------------------------
    logic                    tready;
    logic                    accept;
    logic                    pop;
    logic                    is_dump;
    logic signed [ACC_W-1:0] sum_i;
    logic signed [ACC_W-1:0] sum_q;
    logic [1:0]              dibit;

    // run_q holds tready low during reset and for the first edge after it.
    assign tready   = run_q && (fill_q != 2'd2);
    assign accept   = s_axis_i_tvalid && s_axis_q_tvalid && tready;
    assign pop      = (fill_q != 2'd0) && m_axis_tready;
    assign is_dump  = (smp_cnt_q == LAST_SMP);
    assign sum_i    = acc_i_q + sext(s_axis_i_tdata);
    assign sum_q    = acc_q_q + sext(s_axis_q_tdata);
    assign dibit    = {slice_neg(sum_i), slice_neg(sum_q)};

    assign s_axis_i_tready = tready;
    assign s_axis_q_tready = tready;
    assign m_axis_tvalid   = (fill_q != 2'd0);
    assign m_axis_tdata    = mem_q[rd_ptr_q][7:0];
    assign m_axis_tlast    = mem_q[rd_ptr_q][8];
    assign sym_lock_cnt    = sym_cnt_q;

    always_comb begin
        smp_cnt_d  = smp_cnt_q;
        acc_i_d    = acc_i_q;
        acc_q_d    = acc_q_q;
        dib_cnt_d  = dib_cnt_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;

        if (accept) begin
            if (is_dump) begin
                smp_cnt_d = '0;
                acc_i_d   = '0;
                acc_q_d   = '0;
                sym_cnt_d = sym_cnt_q + 16'd1;
                dib_cnt_d = dib_cnt_q + 2'd1;
                shreg_d   = {shreg_q[3:0], dibit};
                // Fourth dibit completes the byte; the earlier three sit in
                // shreg_q with the oldest in the top bits.
                if (dib_cnt_q == 2'd3) begin
                    mem_d[wr_ptr_q] = {(byte_cnt_q == LAST_BYTE), shreg_q, dibit};
                    wr_ptr_d        = ~wr_ptr_q;
                    byte_cnt_d      = (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + BC_W'(1);
                end
            end else begin
                smp_cnt_d = smp_cnt_q + CNT_W'(1);
                acc_i_d   = sum_i;
                acc_q_d   = sum_q;
            end
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        // A push only happens while not full, a pop only while not empty.
        case ({accept && is_dump && (dib_cnt_q == 2'd3), pop})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            run_q      <= 1'b0;
            smp_cnt_q  <= '0;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            dib_cnt_q  <= '0;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            sym_cnt_q  <= '0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fill_q     <= '0;
        end else begin
            run_q      <= 1'b1;
            smp_cnt_q  <= smp_cnt_d;
            acc_i_q    <= acc_i_d;
            acc_q_q    <= acc_q_d;
            dib_cnt_q  <= dib_cnt_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
        end
    end

endmodule

// File: tb/tb_qpsk_symbol_packer.sv
// Bench for qpsk_symbol_packer. Three instances run side by side:
//   u0: SPS=8,  BYTES_PER_PKT=64
//   u1: SPS=64, BYTES_PER_PKT=64
//   u2: SPS=2,  BYTES_PER_PKT=4
// The reference model sums SPS accepted samples per symbol as plain integers,
// slices on sign, builds bytes arithmetically and keeps the expected output
// bytes in a small ring buffer whose occupancy stands in for the FIFO.
module tb_qpsk_symbol_packer;

    localparam int SPSK [3] = '{8, 64, 2};
    localparam int BPPK [3] = '{64, 64, 4};

    logic               clk;
    logic               rst;
    logic signed [15:0] id  [3];
    logic signed [15:0] qd  [3];
    logic               iv  [3];
    logic               qv  [3];
    logic               itr [3];
    logic               qtr [3];
    logic [7:0]         md  [3];
    logic               mv  [3];
    logic               mr  [3];
    logic               ml  [3];
    logic [15:0]        slc [3];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [8:0] fb [3][4];
    int  hd [3], cnt [3], run [3];
    int  si [3], sq [3], nsmp [3], ndib [3], bacc [3], bcnt [3], syms [3];
    int  npop [3];
    logic [7:0] last_byte [3];
    logic accf [3];

    qpsk_symbol_packer #(.SPS(8), .BYTES_PER_PKT(64)) u0 (
        .ce_clk(clk), .ce_rst(rst),
        .s_axis_i_tdata(id[0]), .s_axis_i_tvalid(iv[0]), .s_axis_i_tready(itr[0]),
        .s_axis_q_tdata(qd[0]), .s_axis_q_tvalid(qv[0]), .s_axis_q_tready(qtr[0]),
        .m_axis_tdata(md[0]), .m_axis_tvalid(mv[0]), .m_axis_tready(mr[0]),
        .m_axis_tlast(ml[0]), .sym_lock_cnt(slc[0]));

    qpsk_symbol_packer #(.SPS(64), .BYTES_PER_PKT(64)) u1 (
        .ce_clk(clk), .ce_rst(rst),
        .s_axis_i_tdata(id[1]), .s_axis_i_tvalid(iv[1]), .s_axis_i_tready(itr[1]),
        .s_axis_q_tdata(qd[1]), .s_axis_q_tvalid(qv[1]), .s_axis_q_tready(qtr[1]),
        .m_axis_tdata(md[1]), .m_axis_tvalid(mv[1]), .m_axis_tready(mr[1]),
        .m_axis_tlast(ml[1]), .sym_lock_cnt(slc[1]));

    qpsk_symbol_packer #(.SPS(2), .BYTES_PER_PKT(4)) u2 (
        .ce_clk(clk), .ce_rst(rst),
        .s_axis_i_tdata(id[2]), .s_axis_i_tvalid(iv[2]), .s_axis_i_tready(itr[2]),
        .s_axis_q_tdata(qd[2]), .s_axis_q_tvalid(qv[2]), .s_axis_q_tready(qtr[2]),
        .m_axis_tdata(md[2]), .m_axis_tvalid(mv[2]), .m_axis_tready(mr[2]),
        .m_axis_tlast(ml[2]), .sym_lock_cnt(slc[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s u%0d observed=0x%0h expected=0x%0h", tag, k, obs, exp);
        end
    endtask

    task automatic mclear(input int k);
        hd[k] = 0; cnt[k] = 0; run[k] = 0;
        si[k] = 0; sq[k] = 0; nsmp[k] = 0; ndib[k] = 0;
        bacc[k] = 0; bcnt[k] = 0; syms[k] = 0;
    endtask

    task automatic check(input int k);
        logic exp_rdy;
        exp_rdy = (run[k] != 0) && (cnt[k] < 2);
        chk("i_tready", k, itr[k], exp_rdy);
        chk("q_tready", k, qtr[k], exp_rdy);
        chk("tvalid", k, mv[k], cnt[k] != 0);
        if (cnt[k] != 0) begin
            chk("tdata", k, md[k], fb[k][hd[k]][7:0]);
            chk("tlast", k, ml[k], fb[k][hd[k]][8]);
        end else if (rst) begin
            chk("rst_tdata", k, md[k], 0);
            chk("rst_tlast", k, ml[k], 0);
        end
        chk("sym_cnt", k, slc[k], syms[k]);
    endtask

    task automatic update(input int k);
        logic rdy;
        if (rst) begin
            mclear(k);
            accf[k] = 1'b0;
            return;
        end
        rdy = (run[k] != 0) && (cnt[k] < 2);
        accf[k] = iv[k] && qv[k] && rdy;
        if (cnt[k] != 0 && mr[k]) begin
            last_byte[k] = md[k];
            npop[k]++;
            hd[k] = (hd[k] + 1) % 4;
            cnt[k]--;
        end
        if (accf[k]) begin
            si[k] += int'(id[k]);
            sq[k] += int'(qd[k]);
            nsmp[k]++;
            if (nsmp[k] == SPSK[k]) begin
                bacc[k] = bacc[k] * 4 + (si[k] < 0 ? 2 : 0) + (sq[k] < 0 ? 1 : 0);
                syms[k] = (syms[k] + 1) % 65536;
                si[k] = 0; sq[k] = 0; nsmp[k] = 0;
                ndib[k]++;
                if (ndib[k] == 4) begin
                    fb[k][(hd[k] + cnt[k]) % 4] = {(bcnt[k] == BPPK[k] - 1), 8'(bacc[k])};
                    cnt[k]++;
                    bcnt[k] = (bcnt[k] + 1) % BPPK[k];
                    ndib[k] = 0;
                    bacc[k] = 0;
                end
            end
        end
        run[k] = 1;
    endtask

    // One clock: check all instances at the falling edge, advance the model
    // for the coming rising edge, then return just after that edge.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) mclear(k);
            check(k);
        end
        for (int k = 0; k < 3; k++) update(k);
        @(posedge clk);
        #1;
    endtask

    task automatic gen(input int mode, input int idx, output logic signed [15:0] i, output logic signed [15:0] q);
        int s;
        s = (idx / 8) % 4;
        case (mode)
            0: begin i = 16'sd100; q = -16'sd100; end
            1: begin
                i = (s == 0 || s == 3) ? 16'sd1000 : -16'sd1000;
                q = (s < 2) ? 16'sd1000 : -16'sd1000;
            end
            2: begin i = -16'sd32768; q = -16'sd32768; end
            3: begin
                if (idx < 8) begin
                    i = (idx % 2 == 0) ? 16'sd1 : -16'sd1;
                    q = -16'sd5;
                end else begin
                    i = 16'sd300; q = 16'sd300;
                end
            end
            default: begin i = 16'($urandom); q = 16'($urandom); end
        endcase
    endtask

    // Feed n pairs to instance k within maxcyc cycles.
    // flags bit0: random valids (sometimes only one), bit1: random m_axis_tready.
    task automatic feed(input int k, input int n, input int mode, input int flags,
                        input int maxcyc, output int got);
        int cyc;
        logic signed [15:0] gi, gq;
        got = 0;
        cyc = 0;
        gen(mode, 0, gi, gq);
        while (got < n && cyc < maxcyc) begin
            id[k] = gi;
            qd[k] = gq;
            iv[k] = (flags[0]) ? ($urandom_range(0, 3) != 0) : 1'b1;
            qv[k] = (flags[0]) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (flags[1]) mr[k] = ($urandom_range(0, 2) != 0);
            tick();
            cyc++;
            if (accf[k]) begin
                got++;
                gen(mode, got, gi, gq);
            end
        end
        iv[k] = 1'b0;
        qv[k] = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; qv[k] = 1'b0; mr[k] = 1'b1;
        end
        repeat (n) tick();
    endtask

    initial begin
        int got;
        int base;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            id[k] = '0; qd[k] = '0; iv[k] = 1'b0; qv[k] = 1'b0; mr[k] = 1'b1;
            npop[k] = 0; last_byte[k] = '0; accf[k] = 1'b0;
            mclear(k);
        end

        // Reset: all outputs zero
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Constant +100/-100 for 32 pairs -> 0x55, four symbols
        feed(0, 32, 0, 0, 200, got);
        chk("t1_pairs", 0, got, 32);
        drain(4);
        chk("t1_byte", 0, last_byte[0], 8'h55);
        chk("t1_syms", 0, slc[0], 4);

        // Sign pattern (+,+),(-,+),(-,-),(+,-) -> 0x2D
        feed(0, 32, 1, 0, 200, got);
        chk("t2_pairs", 0, got, 32);
        drain(4);
        chk("t2_byte", 0, last_byte[0], 8'h2D);

        // Full-scale negative over SPS=64 -> 0xFF
        feed(1, 256, 2, 0, 600, got);
        chk("t3_pairs", 1, got, 256);
        drain(4);
        chk("t3_byte", 1, last_byte[1], 8'hFF);

        // Zero-sum I slices positive: first dibit 01 -> 0x40
        feed(0, 32, 3, 0, 200, got);
        chk("t4_pairs", 0, got, 32);
        drain(4);
        chk("t4_byte", 0, last_byte[0], 8'h40);

        // Output held off for 400 cycles: two bytes queue, input stalls
        mr[2] = 1'b0;
        base = npop[2];
        feed(2, 1000, 4, 0, 400, got);
        chk("t5_held_pairs", 2, got, 16);
        chk("t5_held_tready", 2, itr[2], 0);
        chk("t5_held_tvalid", 2, mv[2], 1);
        mr[2] = 1'b1;
        feed(2, 48, 4, 3, 2000, got);
        chk("t5_more_pairs", 2, got, 48);
        drain(10);
        chk("t5_bytes", 2, npop[2] - base, 8);

        // Random samples, valids and back-pressure
        feed(0, 400, 4, 3, 3000, got);
        chk("t6_pairs", 0, got, 400);
        drain(10);
        feed(2, 300, 4, 3, 3000, got);
        chk("t6b_pairs", 2, got, 300);
        drain(10);

        // Asynchronous reset mid-byte discards the partial work
        feed(0, 20, 0, 0, 100, got);
        chk("t7_pre_pairs", 0, got, 20);
        #2;
        rst = 1'b1;
        repeat (2) tick();
        npop[0] = 0;
        rst = 1'b0;
        repeat (2) tick();
        feed(0, 32, 1, 0, 200, got);
        chk("t7_pairs", 0, got, 32);
        drain(6);
        chk("t7_nbytes", 0, npop[0], 1);
        chk("t7_byte", 0, last_byte[0], 8'h2D);
        chk("t7_syms", 0, slc[0], 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qpsk_symbol_packer.md
Name: qpsk_symbol_packer

Overview:
- Downstream consumer of the Costas loop's phase-corrected I/Q streams (m_axis_i_sync / m_axis_q_sync).
- Integrate-and-dump matched filter over SPS samples per symbol, then QPSK hard-decision slicing to a 2-bit dibit.
- Packs 4 dibits per byte and emits bytes on a single AXI-stream output with a 2-entry output FIFO and periodic tlast framing, ready for the RFNoC output port.

Parameters:
- SPS, 8, samples per symbol; legal range 2..64.
- BYTES_PER_PKT, 64, bytes per output packet; m_axis_tlast is asserted on the last byte; legal range 1..4096.
- ACC_W, 16+$clog2(SPS), accumulator width; must not be overridden below its default.

Ports:
- ce_clk  in  1  block clock.
- ce_rst  in  1  reset, asynchronous, active-high.
- s_axis_i_tdata  in  16  signed I sample from the Costas output.
- s_axis_i_tvalid  in  1  I valid.
- s_axis_i_tready  out  1  I ready.
- s_axis_q_tdata  in  16  signed Q sample.
- s_axis_q_tvalid  in  1  Q valid.
- s_axis_q_tready  out  1  Q ready; always identical to s_axis_i_tready.
- m_axis_tdata  out  8  packed symbol byte.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last byte of packet.
- sym_lock_cnt  out  16  count of symbols decided since reset; wraps at 0xFFFF to 0.

Behaviour:
- Reset:
  - While ce_rst is high, all outputs are 0, including both tready signals.
  - Accumulators, sample counter, dibit counter, byte counter and FIFO are cleared.
  - Reset asserted mid-symbol or mid-byte discards the partial work; nothing is emitted for it.
- Input handshake:
  - s_axis_*_tready = !fifo_full, where fifo_full means 2 entries are stored.
  - A sample pair is accepted only on a cycle where i_tvalid, q_tvalid and tready are all 1.
  - If only one valid is high, nothing is consumed from either stream.
- Integrate-and-dump:
  - Sample counter runs 0..SPS-1 and advances once per accepted pair.
  - Counts 0..SPS-2: acc_i += I and acc_q += Q. Both are sign-extended to ACC_W bits; no saturation is needed because the width is sufficient.
  - Count SPS-1 is the dump cycle:
    - Decision uses sum_i = acc_i + I and sum_q = acc_q + Q.
    - Both accumulators reload to 0 and the counter wraps to 0.
- Slicer (Gray):
  - dibit[1] = sum_i < 0.
  - dibit[0] = sum_q < 0.
  - A sum of exactly 0 slices as positive (bit 0).
  - sym_lock_cnt increments on every dump.
- Packing:
  - The first symbol of a byte occupies bits[7:6], then [5:4], [3:2], [1:0].
  - The dibit counter runs 0..3. On the dump at count 3, the completed byte is pushed into the FIFO in the next cycle.
  - Latency: m_axis_tvalid rises exactly 1 cycle after the acceptance of the final sample of the 4th symbol, when the FIFO was empty beforehand.
- FIFO and framing:
  - 2-entry FIFO; each entry stores {tlast, byte}.
  - The byte counter runs 0..BYTES_PER_PKT-1 and advances on each push; the push at count BYTES_PER_PKT-1 carries tlast=1.
  - Pop happens when m_axis_tvalid && m_axis_tready.
  - Push and pop in the same cycle keep the occupancy unchanged and must preserve order.
  - Because input stalls whenever the FIFO is full, no byte is ever dropped.
  - m_axis_tdata and m_axis_tlast are stable while tvalid=1 and tready=0.
- Reset release: tready rises on the first ce_clk edge after ce_rst deasserts.

Test Plan:
- SPS=8, constant I=+100, Q=-100 for 32 pairs -> one byte 0x55, tvalid one cycle after the 32nd acceptance, sym_lock_cnt=4.
- SPS=8, symbols (I,Q) signs (+,+),(-,+),(-,-),(+,-), 8 samples each -> byte 0b00_10_11_01 = 0x2D.
- SPS=64, all samples I=Q=-32768 for 256 pairs -> byte 0xFF; no accumulator wrap (sum = -2097152 fits in 22 bits).
- Symbol with I samples +1 and -1 alternating (sum 0) and Q=-5 -> dibit 01; zero-sum treated as positive.
- m_axis_tready held 0 for 400 cycles with continuous valid input, SPS=2, BYTES_PER_PKT=4 -> two bytes queue and input tready drops. On release, bytes are delivered in order with no loss. tlast is seen on the 4th, 8th, ... byte.
- Assert ce_rst asynchronously after 20 of 32 pairs, then feed 32 fresh pairs -> exactly one byte is produced, formed from the fresh samples only, and all outputs read 0 during reset.
